// File: rtl/fp_divider.sv
// ----------------------------------------------------------------------------
// fp_divider : sequential IEEE-754 single-precision divider, x3 = x1 / x2.
//
// A radix-2 restoring mantissa divider produces one quotient bit per clock.
// Denormal operands are flushed to zero; results use the same exception and
// flag encodings as the combinational FP32 multiplier in the ALU datapath.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   launch request, sampled only while busy = 0
//   x1, x2     in   dividend / divisor (FP32)
//   busy       out  operation in progress
//   done       out  one-cycle pulse, x3 and flags valid
//   x3         out  quotient (FP32)
//   Exception  out  an operand has exponent 255
//   DivByZero  out  divisor exponent is 0
//   Overflow   out  result exponent >= 255
//   Underflow  out  result exponent <= 0
// ----------------------------------------------------------------------------
module fp_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        busy,
    output logic        done,
    output logic [31:0] x3,
    output logic        Exception,
    output logic        DivByZero,
    output logic        Overflow,
    output logic        Underflow
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DIV   = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;

    // Special-case code latched at acceptance; SP_NONE means iterate.
    localparam logic [1:0] SP_NONE = 2'd0;
    localparam logic [1:0] SP_EXC  = 2'd1;
    localparam logic [1:0] SP_DBZ  = 2'd2;
    localparam logic [1:0] SP_ZERO = 2'd3;

    // Round to nearest, ties to even. Bit 23 of the result is the carry out
    // of the 23-bit mantissa, which bumps the exponent.
    function automatic logic [23:0] round_rne(input logic [22:0] m,
                                              input logic guard,
                                              input logic sticky);
        logic inc;
        inc = guard & (sticky | m[0]);
        return {1'b0, m} + {23'd0, inc};
    endfunction

    // Control state (reset)
    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [31:0] x3_q, x3_d;
    logic        exc_q, exc_d, dbz_q, dbz_d, ovf_q, ovf_d, unf_q, unf_d;

    // Datapath state (no reset)
    logic        sign_q, sign_d;
    logic [7:0]  e1_q, e1_d, e2_q, e2_d;
    logic [23:0] b_q, b_d;
    logic [24:0] r_q, r_d;
    logic [25:0] quo_q, quo_d;
    logic [1:0]  sp_q, sp_d;

    // Normalisation / rounding intermediates
    logic               qbit;
    logic [24:0]        r_sub;
    logic [22:0]        m_pre;
    logic               guard, sticky;
    logic signed [9:0]  exp_pre, exp_fin;
    logic [23:0]        m_rnd;

    always_comb begin
        // Restoring step: compare, conditionally subtract, shift.
        qbit  = (r_q >= {1'b0, b_q});
        r_sub = qbit ? (r_q - {1'b0, b_q}) : r_q;

        // Quotient lies in (0.5, 2); Q[25] tells which side of 1 it is on.
        if (quo_q[25]) begin
            m_pre   = quo_q[24:2];
            guard   = quo_q[1];
            sticky  = quo_q[0] | (|r_q);
            exp_pre = $signed({2'b00, e1_q}) - $signed({2'b00, e2_q}) + 10'sd127;
        end else begin
            m_pre   = quo_q[23:1];
            guard   = quo_q[0];
            sticky  = |r_q;
            exp_pre = $signed({2'b00, e1_q}) - $signed({2'b00, e2_q}) + 10'sd126;
        end
        m_rnd   = round_rne(m_pre, guard, sticky);
        exp_fin = exp_pre + (m_rnd[23] ? 10'sd1 : 10'sd0);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        x3_d    = x3_q;
        exc_d   = exc_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        sign_d  = sign_q;
        e1_d    = e1_q;
        e2_d    = e2_q;
        b_d     = b_q;
        r_d     = r_q;
        quo_d   = quo_q;
        sp_d    = sp_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d = x1[31] ^ x2[31];
                    e1_d   = x1[30:23];
                    e2_d   = x2[30:23];
                    b_d    = {1'b1, x2[22:0]};
                    r_d    = {2'b01, x1[22:0]};
                    quo_d  = 26'd0;
                    cnt_d  = 5'd0;
                    exc_d  = 1'b0;
                    dbz_d  = 1'b0;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    if (x1[30:23] == 8'hFF || x2[30:23] == 8'hFF) sp_d = SP_EXC;
                    else if (x2[30:23] == 8'h00)                  sp_d = SP_DBZ;
                    else if (x1[30:23] == 8'h00)                  sp_d = SP_ZERO;
                    else                                          sp_d = SP_NONE;
                    state_d = (sp_d == SP_NONE) ? DIV : ROUND;
                end
            end
            DIV: begin
                // r_sub < B < 2^24, so bit 24 is always clear before the shift.
                r_d   = {r_sub[23:0], 1'b0};
                quo_d = {quo_q[24:0], qbit};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd25) state_d = ROUND;
            end
            ROUND: begin
                done_d  = 1'b1;
                state_d = IDLE;
                case (sp_q)
                    SP_EXC:  begin x3_d = {sign_q, 8'hFF, 23'd0}; exc_d = 1'b1; end
                    SP_DBZ:  begin x3_d = {sign_q, 8'hFF, 23'd0}; dbz_d = 1'b1; end
                    SP_ZERO: x3_d = {sign_q, 31'd0};
                    default: begin
                        if (exp_fin >= 10'sd255) begin
                            x3_d  = {sign_q, 8'hFF, 23'd0};
                            ovf_d = 1'b1;
                        end else if (exp_fin <= 10'sd0) begin
                            x3_d  = {sign_q, 31'd0};
                            unf_d = 1'b1;
                        end else begin
                            x3_d = {sign_q, exp_fin[7:0], m_rnd[22:0]};
                        end
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            done_q  <= 1'b0;
            x3_q    <= 32'd0;
            exc_q   <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            x3_q    <= x3_d;
            exc_q   <= exc_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        sign_q <= sign_d;
        e1_q   <= e1_d;
        e2_q   <= e2_d;
        b_q    <= b_d;
        r_q    <= r_d;
        quo_q  <= quo_d;
        sp_q   <= sp_d;
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign x3        = x3_q;
    assign Exception = exc_q;
    assign DivByZero = dbz_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;

endmodule

// File: tb/tb_fp_divider.sv
// ----------------------------------------------------------------------------
// tb_fp_divider : directed table-driven bench for fp_divider plus hand-written
// sequences for ignored start, back-to-back launch and reset abort.
// Flags are compared as {Exception, DivByZero, Overflow, Underflow}.
// ----------------------------------------------------------------------------
module tb_fp_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] x1 = 32'd0;
    logic [31:0] x2 = 32'd0;
    logic        busy, done;
    logic [31:0] x3;
    logic        Exception, DivByZero, Overflow, Underflow;

    int n_checks = 0;
    int n_fail   = 0;

    fp_divider dut (
        .clk(clk), .rst(rst), .start(start), .x1(x1), .x2(x2),
        .busy(busy), .done(done), .x3(x3),
        .Exception(Exception), .DivByZero(DivByZero),
        .Overflow(Overflow), .Underflow(Underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [3:0]  flags;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [3:0] flags_now();
        return {Exception, DivByZero, Overflow, Underflow};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at posedge+1; the following edge accepts the request.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        x1 = a; x2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done is seen (bounded).
    task automatic wait_done(output int edges, output int busy_cycles);
        edges = 0; busy_cycles = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cycles++;
            @(posedge clk); #1;
            edges++;
        end
    endtask

    // Counts done pulses over a fixed window.
    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) n++;
        end
    endtask

    int edges, bcyc, nd;

    initial begin
        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 27};
        vecs[2]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 27};
        vecs[3]  = '{32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0010, 27};
        vecs[4]  = '{32'h00800000, 32'h7F000000, 32'h00000000, 4'b0001, 27};
        vecs[5]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, 1};
        vecs[6]  = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 4'b1000, 1};
        vecs[7]  = '{32'h00000000, 32'h40000000, 32'h00000000, 4'b0000, 1};
        vecs[8]  = '{32'hC0000000, 32'h3F000000, 32'hC0800000, 4'b0000, 27};
        vecs[9]  = '{32'h40400000, 32'h40000000, 32'h3FC00000, 4'b0000, 27};
        vecs[10] = '{32'h7F800000, 32'h00000000, 32'h7F800000, 4'b1000, 1};
        vecs[11] = '{32'h00000000, 32'hFF800000, 32'hFF800000, 4'b1000, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy",  {31'd0, busy}, 32'd0);
        check("reset_done",  {31'd0, done}, 32'd0);
        check("reset_x3",    x3, 32'd0);
        check("reset_flags", {28'd0, flags_now()}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            launch(vecs[i].a, vecs[i].b);
            x1 = 32'hDEADBEEF; x2 = 32'h12345678;
            wait_done(edges, bcyc);
            check($sformatf("v%0d_x3", i), x3, vecs[i].q);
            check($sformatf("v%0d_flags", i), {28'd0, flags_now()}, {28'd0, vecs[i].flags});
            check($sformatf("v%0d_latency", i), edges, vecs[i].lat);
            check($sformatf("v%0d_busy_cycles", i), bcyc, vecs[i].lat);
            check($sformatf("v%0d_busy_in_done", i), {31'd0, busy}, 32'd0);
            @(posedge clk); #1;
            check($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
            check($sformatf("v%0d_x3_hold", i), x3, vecs[i].q);
        end

        // Back-to-back: start in the done cycle is accepted, flags clear on accept
        launch(32'h7F000000, 32'h00800000);
        wait_done(edges, bcyc);
        check("b2b_first_ovf", {28'd0, flags_now()}, 32'h2);
        launch(32'h40C00000, 32'h40000000);
        check("b2b_flags_cleared", {28'd0, flags_now()}, 32'd0);
        check("b2b_x3_held", x3, 32'h7F800000);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(edges, bcyc);
        check("b2b_latency", edges, 27);
        check("b2b_x3", x3, 32'h40400000);

        // Start while busy is ignored
        @(posedge clk); #1;
        launch(32'h40C00000, 32'h40000000);
        repeat (4) begin @(posedge clk); #1; end
        launch(32'h3F800000, 32'h40400000);
        x1 = 32'h3F800000; x2 = 32'h40400000;
        wait_done(edges, bcyc);
        check("ign_done_seen", {31'd0, done}, 32'd1);
        check("ign_x3", x3, 32'h40400000);
        check("ign_latency", edges, 22);
        count_dones(40, nd);
        check("ign_no_second_done", nd, 0);

        // Reset during DIV aborts the operation
        launch(32'h40C00000, 32'h40000000);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_x3",    x3, 32'd0);
        check("rst_flags", {28'd0, flags_now()}, 32'd0);
        count_dones(35, nd);
        check("rst_no_done", nd, 0);
        launch(32'h3F800000, 32'h40400000);
        wait_done(edges, bcyc);
        check("rst_fresh_latency", edges, 27);
        check("rst_fresh_x3", x3, 32'h3EAAAAAB);
        check("rst_fresh_flags", {28'd0, flags_now()}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
